// File: rtl/noc_inject_arb_if.sv
// ---------------------------------------------------------------------------
// noc_inject_arb_if
//
// Purpose: groups the request, network-send and status signals of the
// NoC injection arbiter into one bundle. Clock and reset are not part of it.
//
// Signals:
//   req_valid    [3:0]    per-PE request to inject one flit
//   req_data     [255:0]  per-PE payload, requester i on [64i+63:64i]
//   req_dest     [7:0]    per-PE destination port, requester i on [2i+1:2i]
//   req_ready    [3:0]    one-hot accept back to the PEs
//   o_flit       [68:0]   registered flit to network send port 0
//   o_flit_valid          network putFlit enable
//   i_credit     [1:0]    network getCredits: [1]=credit valid, [0]=VC
//   credit_cnt   [3:0]    currently available credits
//   grant_id     [1:0]    index of the last accepted requester
//   starved               high while the arbiter sits in the STARVED state
//   credit_err            sticky credit protocol error
//
// Optional: with NOC_INJECT_ARB_STATS_EN defined, the bundle also carries
//   grant_count  [63:0]   four 16-bit saturating per-requester accept counters
//   stall_count  [15:0]   saturating count of WAIT_CREDIT/STARVED cycles
//
// Modports: slave = arbiter side, master = PE/network/testbench side.
// ---------------------------------------------------------------------------
interface noc_inject_arb_if;
    logic [3:0]   req_valid;
    logic [255:0] req_data;
    logic [7:0]   req_dest;
    logic [3:0]   req_ready;
    logic [68:0]  o_flit;
    logic         o_flit_valid;
    logic [1:0]   i_credit;
    logic [3:0]   credit_cnt;
    logic [1:0]   grant_id;
    logic         starved;
    logic         credit_err;
`ifdef NOC_INJECT_ARB_STATS_EN
    logic [63:0]  grant_count;
    logic [15:0]  stall_count;

    modport slave (
        input  req_valid, req_data, req_dest, i_credit,
        output req_ready, o_flit, o_flit_valid, credit_cnt, grant_id, starved, credit_err,
        output grant_count, stall_count
    );

    modport master (
        output req_valid, req_data, req_dest, i_credit,
        input  req_ready, o_flit, o_flit_valid, credit_cnt, grant_id, starved, credit_err,
        input  grant_count, stall_count
    );
`else
    modport slave (
        input  req_valid, req_data, req_dest, i_credit,
        output req_ready, o_flit, o_flit_valid, credit_cnt, grant_id, starved, credit_err
    );

    modport master (
        output req_valid, req_data, req_dest, i_credit,
        input  req_ready, o_flit, o_flit_valid, credit_cnt, grant_id, starved, credit_err
    );
`endif
endinterface

// File: rtl/noc_inject_arb.sv
// ---------------------------------------------------------------------------
// noc_inject_arb
//
// Purpose: credit-based injection arbiter. Four processing elements compete
// to inject single-flit packets into network send port 0. One requester is
// accepted per cycle in round-robin order (the first grant after reset goes
// to requester 0), only while a network input-buffer credit is available.
// The accepted flit is registered and presented to the network one cycle
// later. Credits are consumed on accept and returned via i_credit.
//
// Ports:
//   Clk   single clock, all state updates on its rising edge
//   Rst   synchronous active-high reset
//   bus   noc_inject_arb_if.slave: requests, flit output, credit return
//         and status (see noc_inject_arb_if.sv)
//
// Parameters:
//   NUM_CREDITS   network input-buffer depth / credit reset value (1..15)
//   STARVE_LIMIT  cycles a requester may wait with valid held before the
//                 STARVED state is flagged
//
// Optional feature: define NOC_INJECT_ARB_STATS_EN to add the grant_count and
// stall_count statistics counters. Without it the counters do not exist and
// all other behaviour is identical.
// ---------------------------------------------------------------------------
module noc_inject_arb #(
    parameter int unsigned NUM_CREDITS  = 4,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input logic              Clk,
    input logic              Rst,
    noc_inject_arb_if.slave  bus
);

    localparam int unsigned  WaitW     = $clog2(STARVE_LIMIT + 1);
    localparam logic [3:0]   CreditMax = 4'(NUM_CREDITS);
    localparam logic [WaitW-1:0] WaitMax = WaitW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        StIdle       = 2'd0,
        StActive     = 2'd1,
        StWaitCredit = 2'd2,
        StStarved    = 2'd3
    } state_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e                    state_q, state_d;
    logic [3:0]                credit_cnt_q, credit_cnt_d;
    logic                      credit_err_q, credit_err_d;
    logic [1:0]                rr_ptr_q, rr_ptr_d;
    logic [1:0]                grant_id_q, grant_id_d;
    logic [68:0]               o_flit_q, o_flit_d;
    logic                      o_flit_valid_q, o_flit_valid_d;
    logic [3:0][WaitW-1:0]     wait_cnt_q, wait_cnt_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [3:0] grant_oh;
    logic [1:0] grant_idx;
    logic [1:0] scan_idx;
    logic       accept;
    logic       credit_ok;
    logic       credit_vc_err;
    logic       starve_hit;
    logic [63:0] sel_data;
    logic [1:0]  sel_dest;

    // Round-robin search starting at rr_ptr_q. Reset and an empty credit pool
    // both mask every grant, so req_ready can never be high in those cases.
    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        scan_idx  = '0;
        accept    = 1'b0;
        if (!Rst && (credit_cnt_q != '0)) begin
            for (int k = 0; k < 4; k++) begin
                scan_idx = rr_ptr_q + 2'(k);
                if (!accept && bus.req_valid[scan_idx]) begin
                    accept              = 1'b1;
                    grant_idx           = scan_idx;
                    grant_oh[scan_idx]  = 1'b1;
                end
            end
        end
    end

    assign sel_data = bus.req_data[{grant_idx, 6'd0} +: 64];
    assign sel_dest = bus.req_dest[{grant_idx, 1'b0} +: 2];

    // Only VC 0 exists; a credit tagged for VC 1 is a protocol error.
    assign credit_ok     = bus.i_credit[1] && !bus.i_credit[0];
    assign credit_vc_err = bus.i_credit[1] &&  bus.i_credit[0];

    // Credit accounting: a simultaneous accept and return cancel out. A return
    // with the pool already full saturates and flags the error.
    always_comb begin
        credit_cnt_d = credit_cnt_q;
        credit_err_d = credit_err_q;
        case ({accept, credit_ok})
            2'b10: credit_cnt_d = credit_cnt_q - 4'd1;
            2'b01: begin
                if (credit_cnt_q >= CreditMax) begin
                    credit_cnt_d = CreditMax;
                    credit_err_d = 1'b1;
                end else begin
                    credit_cnt_d = credit_cnt_q + 4'd1;
                end
            end
            default: credit_cnt_d = credit_cnt_q;
        endcase
        if (credit_vc_err) begin
            credit_err_d = 1'b1;
        end
    end

    // Flit register, grant bookkeeping and round-robin pointer.
    always_comb begin
        o_flit_valid_d = accept;
        o_flit_d       = o_flit_q;
        grant_id_d     = grant_id_q;
        rr_ptr_d       = rr_ptr_q;
        if (accept) begin
            o_flit_d   = {1'b1, 1'b1, 1'b0, sel_dest, sel_data};
            grant_id_d = grant_idx;
            rr_ptr_d   = grant_idx + 2'd1;
        end
    end

    // Per-requester wait counters: consecutive cycles with valid held and no
    // grant. They saturate at STARVE_LIMIT and clear as soon as the requester
    // is granted or withdraws.
    always_comb begin
        wait_cnt_d = '0;
        starve_hit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (bus.req_valid[i] && !grant_oh[i]) begin
                wait_cnt_d[i] = (wait_cnt_q[i] >= WaitMax) ? WaitMax
                                                           : wait_cnt_q[i] + WaitW'(1);
            end else begin
                wait_cnt_d[i] = '0;
            end
            if (wait_cnt_d[i] >= WaitMax) begin
                starve_hit = 1'b1;
            end
        end
    end

    // FSM next state. The state reflects the request/credit situation the
    // arbiter will see in the coming cycle, so it is derived from credit_cnt_d.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StStarved: begin
                if (bus.req_valid == '0) begin
                    state_d = StIdle;
                end else if (credit_ok) begin
                    state_d = StActive;
                end else begin
                    state_d = StStarved;
                end
            end
            default: begin
                if (bus.req_valid == '0) begin
                    state_d = StIdle;
                end else if (credit_cnt_d != '0) begin
                    state_d = StActive;
                end else if ((state_q == StWaitCredit) && starve_hit) begin
                    state_d = StStarved;
                end else begin
                    state_d = StWaitCredit;
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q        <= StIdle;
            credit_cnt_q   <= CreditMax;
            credit_err_q   <= 1'b0;
            rr_ptr_q       <= '0;
            grant_id_q     <= '0;
            o_flit_q       <= '0;
            o_flit_valid_q <= 1'b0;
            wait_cnt_q     <= '0;
        end else begin
            state_q        <= state_d;
            credit_cnt_q   <= credit_cnt_d;
            credit_err_q   <= credit_err_d;
            rr_ptr_q       <= rr_ptr_d;
            grant_id_q     <= grant_id_d;
            o_flit_q       <= o_flit_d;
            o_flit_valid_q <= o_flit_valid_d;
            wait_cnt_q     <= wait_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.req_ready    = grant_oh;
    assign bus.o_flit       = o_flit_q;
    assign bus.o_flit_valid = o_flit_valid_q;
    assign bus.credit_cnt   = credit_cnt_q;
    assign bus.grant_id     = grant_id_q;
    assign bus.starved      = (state_q == StStarved);
    assign bus.credit_err   = credit_err_q;

`ifdef NOC_INJECT_ARB_STATS_EN
    // ------------------------------------------------------------------
    // Statistics counters (all saturating)
    // ------------------------------------------------------------------
    logic [3:0][15:0] grant_count_q, grant_count_d;
    logic [15:0]      stall_count_q, stall_count_d;

    always_comb begin
        grant_count_d = grant_count_q;
        stall_count_d = stall_count_q;
        if (accept && (grant_count_q[grant_idx] != 16'hFFFF)) begin
            grant_count_d[grant_idx] = grant_count_q[grant_idx] + 16'd1;
        end
        if (((state_q == StWaitCredit) || (state_q == StStarved))
                && (stall_count_q != 16'hFFFF)) begin
            stall_count_d = stall_count_q + 16'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            grant_count_q <= '0;
            stall_count_q <= '0;
        end else begin
            grant_count_q <= grant_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign bus.grant_count = grant_count_q;
    assign bus.stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_noc_inject_arb.sv
// ---------------------------------------------------------------------------
// tb_noc_inject_arb
//
// Directed bench for noc_inject_arb. Expected flits are pushed into a
// scoreboard queue when a request is driven; a monitor pops and compares on
// every cycle the arbiter presents o_flit_valid. Handshake, credit and status
// values are checked inline against hand-computed constants.
// ---------------------------------------------------------------------------
module tb_noc_inject_arb;

    logic Clk = 1'b0;
    logic Rst;

    always #5 Clk = ~Clk;

    noc_inject_arb_if bus_if ();

    noc_inject_arb #(
        .NUM_CREDITS  (4),
        .STARVE_LIMIT (8)
    ) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus_if)
    );

    typedef struct packed {
        logic [68:0] flit;
        logic [1:0]  gid;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    function automatic logic [68:0] mk_flit(input logic [1:0] dest, input logic [63:0] data);
        return {1'b1, 1'b1, 1'b0, dest, data};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [1:0] dest, input logic [63:0] data, input logic [1:0] gid);
        exp_t e;
        e.flit = mk_flit(dest, data);
        e.gid  = gid;
        sb_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Monitor: every presented flit must match the oldest expected entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            if (bus_if.o_flit_valid === 1'b1) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_flit: got %0h expected none", bus_if.o_flit);
                end else begin
                    e = sb_q.pop_front();
                    chk("flit", 128'(bus_if.o_flit), 128'(e.flit));
                    chk("flit_grant_id", 128'(bus_if.grant_id), 128'(e.gid));
                end
            end
        end
    end

    initial begin
        Rst              = 1'b1;
        bus_if.req_valid = 4'hF;
        bus_if.req_data  = '0;
        bus_if.req_dest  = '0;
        bus_if.i_credit  = 2'b00;

        // Reset: no ready while Rst is high, then reset values.
        @(negedge Clk);
        chk("ready_in_reset", 128'(bus_if.req_ready), 128'h0);
        tick();
        Rst              = 1'b0;
        bus_if.req_valid = 4'h0;
        @(negedge Clk);
        chk("rst_credit_cnt", 128'(bus_if.credit_cnt), 128'd4);
        chk("rst_flit_valid", 128'(bus_if.o_flit_valid), 128'd0);
        chk("rst_flit", 128'(bus_if.o_flit), 128'd0);
        chk("rst_grant_id", 128'(bus_if.grant_id), 128'd0);
        chk("rst_starved", 128'(bus_if.starved), 128'd0);
        chk("rst_credit_err", 128'(bus_if.credit_err), 128'd0);
        tick();

        // Single request from PE0, dest 2, data 0xA5.
        bus_if.req_valid = 4'b0001;
        bus_if.req_dest  = 8'h02;
        bus_if.req_data  = 256'hA5;
        push(2'd2, 64'hA5, 2'd0);
        @(negedge Clk);
        chk("t1_ready", 128'(bus_if.req_ready), 128'b0001);
        tick();
        bus_if.req_valid = 4'b0000;
        @(negedge Clk);
        chk("t1_credit_cnt", 128'(bus_if.credit_cnt), 128'd3);
        tick();

        // Reset pulse so the round-robin pointer starts at 0 again.
        Rst = 1'b1;
        tick();
        Rst = 1'b0;

        // All four requesting, no credit return: grants 0,1,2,3 then stall.
        bus_if.req_data  = {64'h1003, 64'h1002, 64'h1001, 64'h1000};
        bus_if.req_dest  = 8'b11_10_01_00;
        bus_if.req_valid = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            push(2'(k), 64'h1000 + 64'(k), 2'(k));
            @(negedge Clk);
            chk("t2_ready", 128'(bus_if.req_ready), 128'(4'b0001 << k));
            tick();
        end
        @(negedge Clk);
        chk("t2_ready_empty", 128'(bus_if.req_ready), 128'h0);
        chk("t2_credit_cnt", 128'(bus_if.credit_cnt), 128'd0);
        chk("t2_state_wait_credit", 128'(dut.state_q), 128'd2);
        tick();
        bus_if.req_valid = 4'b0000;
        @(negedge Clk);
        chk("t2_flit_valid_low", 128'(bus_if.o_flit_valid), 128'd0);
        tick();

        // PE2 alone with no credits: starved after 8 cycles, cleared by a credit.
        bus_if.req_valid = 4'b0100;
        for (int a = 0; a < 8; a++) begin
            @(negedge Clk);
            chk("t3_not_starved", 128'(bus_if.starved), 128'd0);
            chk("t3_ready_none", 128'(bus_if.req_ready), 128'h0);
            tick();
        end
        bus_if.i_credit = 2'b10;
        @(negedge Clk);
        chk("t3_starved", 128'(bus_if.starved), 128'd1);
        tick();
        bus_if.i_credit = 2'b00;
        push(2'd2, 64'h1002, 2'd2);
        @(negedge Clk);
        chk("t3_ready_after_credit", 128'(bus_if.req_ready), 128'b0100);
        chk("t3_starved_cleared", 128'(bus_if.starved), 128'd0);
        tick();
        bus_if.req_valid = 4'b0000;
        @(negedge Clk);
        chk("t3_credit_cnt", 128'(bus_if.credit_cnt), 128'd0);
        tick();

        // Two credits back, then accept and credit return in the same cycle.
        bus_if.i_credit = 2'b10;
        tick();
        tick();
        bus_if.req_valid = 4'b0001;
        push(2'd0, 64'h1000, 2'd0);
        @(negedge Clk);
        chk("t4_credit_before", 128'(bus_if.credit_cnt), 128'd2);
        chk("t4_ready", 128'(bus_if.req_ready), 128'b0001);
        tick();
        bus_if.i_credit  = 2'b00;
        bus_if.req_valid = 4'b0000;
        @(negedge Clk);
        chk("t4_credit_after", 128'(bus_if.credit_cnt), 128'd2);
        tick();

        // Fill to 4, then an extra credit saturates and sets the sticky error.
        bus_if.i_credit = 2'b10;
        tick();
        tick();
        bus_if.i_credit = 2'b00;
        @(negedge Clk);
        chk("t5_credit_full", 128'(bus_if.credit_cnt), 128'd4);
        chk("t5_err_clear", 128'(bus_if.credit_err), 128'd0);
        tick();
        bus_if.i_credit = 2'b10;
        tick();
        bus_if.i_credit = 2'b00;
        @(negedge Clk);
        chk("t5_credit_sat", 128'(bus_if.credit_cnt), 128'd4);
        chk("t5_err_set", 128'(bus_if.credit_err), 128'd1);
        tick();
        @(negedge Clk);
        chk("t5_err_sticky", 128'(bus_if.credit_err), 128'd1);
        tick();

        // Back-to-back grants (pointer at 1), reset mid-stream.
        bus_if.req_valid = 4'b1111;
        push(2'd1, 64'h1001, 2'd1);
        @(negedge Clk);
        chk("t6_ready_b1", 128'(bus_if.req_ready), 128'b0010);
        tick();
        push(2'd2, 64'h1002, 2'd2);
        @(negedge Clk);
        chk("t6_ready_b2", 128'(bus_if.req_ready), 128'b0100);
        tick();
        Rst = 1'b1;
        @(negedge Clk);
        chk("t6_ready_in_reset", 128'(bus_if.req_ready), 128'h0);
        tick();
        Rst              = 1'b0;
        bus_if.req_valid = 4'b0000;
        @(negedge Clk);
        chk("t6_flit_valid", 128'(bus_if.o_flit_valid), 128'd0);
        chk("t6_credit_cnt", 128'(bus_if.credit_cnt), 128'd4);
        chk("t6_err_cleared", 128'(bus_if.credit_err), 128'd0);
        chk("t6_grant_id", 128'(bus_if.grant_id), 128'd0);
        tick();
        bus_if.req_valid = 4'b1111;
        push(2'd0, 64'h1000, 2'd0);
        @(negedge Clk);
        chk("t6_ready_first", 128'(bus_if.req_ready), 128'b0001);
        tick();

        // A credit tagged for VC 1 is ignored but flags the error.
        bus_if.req_valid = 4'b0000;
        bus_if.i_credit  = 2'b11;
        @(negedge Clk);
        chk("t7_credit_before", 128'(bus_if.credit_cnt), 128'd3);
        tick();
        bus_if.i_credit = 2'b00;
        @(negedge Clk);
        chk("t7_credit_after", 128'(bus_if.credit_cnt), 128'd3);
        chk("t7_err_vc", 128'(bus_if.credit_err), 128'd1);
        tick();

        repeat (3) tick();
        chk("scoreboard_drained", 128'(sb_q.size()), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/noc_inject_arb.md
NOC_INJECT_ARB -- requirements
Module: noc_inject_arb

Interface
REQ-001 SHALL provide parameter NUM_CREDITS, default 4, meaning network input-buffer depth and credit counter reset value (legal range 1..15).
REQ-002 SHALL provide parameter STARVE_LIMIT, default 8, meaning the number of cycles a requester waits while holding valid before the STARVED state is flagged.
REQ-003 SHALL provide port Clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL provide port Rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL provide port req_valid, input, 4 bits: per-PE request to inject one flit.
REQ-006 SHALL provide port req_data, input, 256 bits: per-PE payload, requester i on [64i+63:64i].
REQ-007 SHALL provide port req_dest, input, 8 bits: per-PE destination port, requester i on [2i+1:2i].
REQ-008 SHALL provide port req_ready, output, 4 bits: one-hot accept; a flit transfers when req_valid[i] and req_ready[i] are both high.
REQ-009 SHALL provide port o_flit, output, 69 bits: registered flit to network send port 0.
REQ-010 SHALL provide port o_flit_valid, output, 1 bit: drives the network putFlit enable.
REQ-011 SHALL provide port i_credit, input, 2 bits: network getCredits; [1]=credit valid, [0]=VC (VC must be 0).
REQ-012 SHALL provide port credit_cnt, output, 4 bits: currently available credits.
REQ-013 SHALL provide port grant_id, output, 2 bits: index of the last accepted requester.
REQ-014 SHALL provide port starved, output, 1 bit: high while in STARVED state.
REQ-015 SHALL provide port credit_err, output, 1 bit: sticky error flag.

Function
REQ-016 SHALL form the flit as [68]=1 valid, [67]=1 tail, [66]=0 VC, [65:64]=req_dest, [63:0]=req_data.
REQ-017 SHALL grant at most one requester per cycle, round-robin starting after the last grant; the first grant after reset SHALL go to requester 0.
REQ-018 SHALL assert req_ready combinationally, only when credit_cnt>0, and only toward a valid requester.
REQ-019 SHALL register o_flit and o_flit_valid one cycle after accept (latency 1); o_flit_valid SHALL be low in every cycle after a cycle with no accept.
REQ-020 SHALL decrement credit_cnt by 1 on accept and increment it by 1 on i_credit[1]; when both occur in the same cycle, credit_cnt SHALL be unchanged.
REQ-021 SHALL saturate credit_cnt at NUM_CREDITS when a credit returns at NUM_CREDITS (with no accept that cycle) and set credit_err.
REQ-022 SHALL set credit_err on i_credit[1] with i_credit[0]=1 and otherwise ignore that credit.
REQ-023 SHALL implement FSM states IDLE (no req_valid), ACTIVE (req_valid and credit_cnt>0), WAIT_CREDIT (req_valid and credit_cnt=0), and STARVED.
REQ-024 SHALL enter STARVED from WAIT_CREDIT when any single requester has been valid without grant for STARVE_LIMIT consecutive cycles.
REQ-025 SHALL leave STARVED to ACTIVE on the first credit return, and to IDLE when req_valid becomes 0.
REQ-026 SHALL update grant_id only on accept.
REQ-027 SHALL NOT grant a requester whose req_valid drops in the same cycle it would be granted.

Reset
REQ-028 SHALL, on Rst high at a clock edge, set credit_cnt=NUM_CREDITS, o_flit=0, o_flit_valid=0, grant_id=0, round-robin pointer to 0, FSM=IDLE, starved=0, credit_err=0, and all wait counters to 0.
REQ-029 SHALL hold req_ready=0 while Rst is high.
REQ-030 SHALL drop any flit accepted in the cycle Rst is asserted; reset mid-operation SHALL discard all outstanding credits.

Configuration
REQ-031 SHALL, with macro NOC_INJECT_ARB_STATS_EN defined, add output grant_count (64 bits: four 16-bit saturating per-requester accept counters) and output stall_count (16 bits: saturating count of WAIT_CREDIT and STARVED cycles), all cleared by Rst.
REQ-032 SHALL, without NOC_INJECT_ARB_STATS_EN, omit those ports and counters, with all other behaviour identical.

Verification
REQ-033 SHALL verify: after reset, req_valid=4'b0001, req_dest[1:0]=2, data=0xA5 -> req_ready=0001 same cycle, next cycle o_flit_valid=1, o_flit[65:64]=2, o_flit[63:0]=0xA5, credit_cnt=3.
REQ-034 SHALL verify: req_valid=4'b1111 held 4 cycles, no credit return -> grants 0,1,2,3 in order, credit_cnt=0, fifth cycle req_ready=0 and state WAIT_CREDIT.
REQ-035 SHALL verify: credit_cnt=0, req_valid=4'b0100 held 8 cycles -> starved=1; then i_credit=2'b10 -> next cycle grant to 2, starved=0.
REQ-036 SHALL verify: credit_cnt=2, accept plus i_credit=2'b10 in the same cycle -> credit_cnt stays 2.
REQ-037 SHALL verify: credit_cnt=4, i_credit=2'b10 -> credit_cnt=4 and credit_err=1 until Rst.
REQ-038 SHALL verify: Rst asserted during back-to-back grants -> next cycle o_flit_valid=0, credit_cnt=4, and the following grant goes to requester 0.
